// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter for add/mul/branch result broadcast (optional round-robin: CDB_RR_EN)
`timescale 1ns/1ps

module cdb_arbiter #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3
) (
    input  logic              clk1,
    input  logic              rst,

    input  logic              add_valid,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_data,
    output logic              add_ready,

    input  logic              mul_valid,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_data,
    output logic              mul_ready,

    input  logic              bch_valid,
    input  logic [TAG_W-1:0]  bch_tag,
    input  logic [DATA_W-1:0] bch_data,
    output logic              bch_ready,

    input  logic              cdb_stall,

    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src
);

    localparam logic [1:0] SRC_ADD = 2'd0;
    localparam logic [1:0] SRC_MUL = 2'd1;
    localparam logic [1:0] SRC_BCH = 2'd2;

    logic [1:0]        prio_q, prio_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    logic [2:0]        req;
    logic [2:0]        gnt;
    logic              gnt_any;
    logic [1:0]        win;

    assign req = {bch_valid, mul_valid, add_valid};

    // Pick the first valid requester starting at prio; nothing is granted in reset or stall.
    always_comb begin
        gnt     = 3'b000;
        gnt_any = 1'b0;
        win     = SRC_ADD;
        if (!rst && !cdb_stall) begin
            case (prio_q)
                2'd1: begin
                    if (req[1])      win = SRC_MUL;
                    else if (req[2]) win = SRC_BCH;
                    else             win = SRC_ADD;
                end
                2'd2: begin
                    if (req[2])      win = SRC_BCH;
                    else if (req[0]) win = SRC_ADD;
                    else             win = SRC_MUL;
                end
                default: begin
                    if (req[0])      win = SRC_ADD;
                    else if (req[1]) win = SRC_MUL;
                    else             win = SRC_BCH;
                end
            endcase
            gnt_any = |req;
            if (gnt_any) gnt[win] = 1'b1;
        end
    end

    assign add_ready = gnt[0];
    assign mul_ready = gnt[1];
    assign bch_ready = gnt[2];

    // Next broadcast: load the winner, clear valid when idle, freeze everything under stall.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (!cdb_stall) begin
            cdb_valid_d = gnt_any;
            if (gnt_any) begin
                cdb_src_d = win;
                case (win)
                    SRC_MUL: begin
                        cdb_tag_d  = mul_tag;
                        cdb_data_d = mul_data;
                    end
                    SRC_BCH: begin
                        cdb_tag_d  = bch_tag;
                        cdb_data_d = bch_data;
                    end
                    default: begin
                        cdb_tag_d  = add_tag;
                        cdb_data_d = add_data;
                    end
                endcase
            end
        end
    end

    // Priority pointer: after a transfer the winner's successor leads; fixed policy pins it at add.
    always_comb begin
`ifdef CDB_RR_EN
        prio_d = prio_q;
        if (gnt_any) prio_d = (win == SRC_BCH) ? 2'd0 : win + 2'd1;
`else
        prio_d = 2'd0;
`endif
    end

    // State registers; reset discards any held broadcast and restarts priority at add.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            prio_q      <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= 2'd0;
        end else begin
            prio_q      <= prio_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
`timescale 1ns/1ps

module tb_cdb_arbiter;

    logic       clk1 = 1'b0;
    logic       rst  = 1'b1;
    logic       add_valid = 1'b0, mul_valid = 1'b0, bch_valid = 1'b0;
    logic [2:0] add_tag = '0, mul_tag = '0, bch_tag = '0;
    logic [7:0] add_data = '0, mul_data = '0, bch_data = '0;
    logic       add_ready, mul_ready, bch_ready;
    logic       cdb_stall = 1'b0;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [7:0] cdb_data;
    logic [1:0] cdb_src;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  rdy_obs;
    logic [13:0] bus_obs;

    assign rdy_obs = {bch_ready, mul_ready, add_ready};
    assign bus_obs = {cdb_valid, cdb_src, cdb_tag, cdb_data};

    cdb_arbiter #(.DATA_W(8), .TAG_W(3)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .add_valid (add_valid),
        .add_tag   (add_tag),
        .add_data  (add_data),
        .add_ready (add_ready),
        .mul_valid (mul_valid),
        .mul_tag   (mul_tag),
        .mul_data  (mul_data),
        .mul_ready (mul_ready),
        .bch_valid (bch_valid),
        .bch_tag   (bch_tag),
        .bch_data  (bch_data),
        .bch_ready (bch_ready),
        .cdb_stall (cdb_stall),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        add_valid = 1'b1; add_tag = 3'd1; add_data = 8'h11;
        mul_valid = 1'b1; mul_tag = 3'd2; mul_data = 8'h22;
        bch_valid = 1'b1; bch_tag = 3'd4; bch_data = 8'h44;
        tick();
        checks++;
        if (rdy_obs !== 3'b000) begin
            failures++; $display("FAIL reset_ready got=%b want=000", rdy_obs);
        end
        checks++;
        if (bus_obs !== 14'h0) begin
            failures++; $display("FAIL reset_bus got=%h want=0000", bus_obs);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy_obs !== 3'b001) begin
            failures++; $display("FAIL first_grant got=%b want=001", rdy_obs);
        end
        tick();
        checks++;
        if (bus_obs !== {1'b1, 2'd0, 3'd1, 8'h11}) begin
            failures++; $display("FAIL first_bcast got=%h want=%h", bus_obs, {1'b1, 2'd0, 3'd1, 8'h11});
        end
        add_valid = 1'b0; mul_valid = 1'b0; bch_valid = 1'b0;
        tick();
        checks++;
        if (bus_obs !== {1'b0, 2'd0, 3'd1, 8'h11}) begin
            failures++; $display("FAIL idle_hold got=%h want=%h", bus_obs, {1'b0, 2'd0, 3'd1, 8'h11});
        end
    endtask

    task automatic test_single();
        mul_valid = 1'b1; mul_tag = 3'd5; mul_data = 8'h2A;
        #1;
        checks++;
        if (rdy_obs !== 3'b010) begin
            failures++; $display("FAIL single_ready got=%b want=010", rdy_obs);
        end
        tick();
        mul_valid = 1'b0;
        checks++;
        if (bus_obs !== {1'b1, 2'd1, 3'd5, 8'h2A}) begin
            failures++; $display("FAIL single_bcast got=%h want=%h", bus_obs, {1'b1, 2'd1, 3'd5, 8'h2A});
        end
        #1;
        checks++;
        if (rdy_obs !== 3'b000) begin
            failures++; $display("FAIL single_ready_after got=%b want=000", rdy_obs);
        end
        tick();
        checks++;
        if (bus_obs !== {1'b0, 2'd1, 3'd5, 8'h2A}) begin
            failures++; $display("FAIL single_drop got=%h want=%h", bus_obs, {1'b0, 2'd1, 3'd5, 8'h2A});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  tags [3];
        logic [7:0]  datas [3];
        logic [1:0]  w;
        logic [13:0] exp_bus;
        tags[0] = 3'd1; tags[1] = 3'd2; tags[2] = 3'd3;
        datas[0] = 8'hA1; datas[1] = 8'hB2; datas[2] = 8'hC3;
        pulse_reset();
        add_valid = 1'b1; add_tag = tags[0]; add_data = datas[0];
        mul_valid = 1'b1; mul_tag = tags[1]; mul_data = datas[1];
        bch_valid = 1'b1; bch_tag = tags[2]; bch_data = datas[2];
        for (int k = 0; k < 6; k++) begin
`ifdef CDB_RR_EN
            w = 2'(k % 3);
`else
            w = 2'd0;
`endif
            #1;
            checks++;
            if (rdy_obs !== (3'b001 << w)) begin
                failures++; $display("FAIL b2b_ready[%0d] got=%b want=%b", k, rdy_obs, 3'b001 << w);
            end
            tick();
            exp_bus = {1'b1, w, tags[w], datas[w]};
            checks++;
            if (bus_obs !== exp_bus) begin
                failures++; $display("FAIL b2b_bcast[%0d] got=%h want=%h", k, bus_obs, exp_bus);
            end
        end
        add_valid = 1'b0; mul_valid = 1'b0; bch_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        pulse_reset();
        add_valid = 1'b1; add_tag = 3'd3; add_data = 8'h33;
        #1;
        checks++;
        if (rdy_obs !== 3'b001) begin
            failures++; $display("FAIL stall_pre_ready got=%b want=001", rdy_obs);
        end
        tick();
        add_valid = 1'b0;
        bch_valid = 1'b1; bch_tag = 3'd6; bch_data = 8'h66;
        cdb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rdy_obs !== 3'b000) begin
                failures++; $display("FAIL stall_ready[%0d] got=%b want=000", k, rdy_obs);
            end
            tick();
            checks++;
            if (bus_obs !== {1'b1, 2'd0, 3'd3, 8'h33}) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h want=%h", k, bus_obs, {1'b1, 2'd0, 3'd3, 8'h33});
            end
        end
        cdb_stall = 1'b0;
        #1;
        checks++;
        if (rdy_obs !== 3'b100) begin
            failures++; $display("FAIL stall_release_ready got=%b want=100", rdy_obs);
        end
        tick();
        bch_valid = 1'b0;
        checks++;
        if (bus_obs !== {1'b1, 2'd2, 3'd6, 8'h66}) begin
            failures++; $display("FAIL stall_release_bcast got=%h want=%h", bus_obs, {1'b1, 2'd2, 3'd6, 8'h66});
        end
        tick();
        checks++;
        if (bus_obs !== {1'b0, 2'd2, 3'd6, 8'h66}) begin
            failures++; $display("FAIL stall_release_drop got=%h want=%h", bus_obs, {1'b0, 2'd2, 3'd6, 8'h66});
        end
    endtask

    task automatic test_reset_mid_stall();
        pulse_reset();
        add_valid = 1'b1; add_tag = 3'd7; add_data = 8'h77;
        tick();
        add_valid = 1'b0;
        mul_valid = 1'b1; mul_tag = 3'd2; mul_data = 8'h22;
        cdb_stall = 1'b1;
        tick();
        checks++;
        if (bus_obs !== {1'b1, 2'd0, 3'd7, 8'h77}) begin
            failures++; $display("FAIL rms_held got=%h want=%h", bus_obs, {1'b1, 2'd0, 3'd7, 8'h77});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_obs !== 14'h0) begin
            failures++; $display("FAIL rms_async_clear got=%h want=0000", bus_obs);
        end
        checks++;
        if (rdy_obs !== 3'b000) begin
            failures++; $display("FAIL rms_ready_in_reset got=%b want=000", rdy_obs);
        end
        rst = 1'b0;
        cdb_stall = 1'b0;
        add_valid = 1'b1; bch_valid = 1'b1; bch_tag = 3'd4; bch_data = 8'h44;
        #1;
        checks++;
        if (rdy_obs !== 3'b001) begin
            failures++; $display("FAIL rms_prio0 got=%b want=001", rdy_obs);
        end
        tick();
        checks++;
        if (bus_obs !== {1'b1, 2'd0, 3'd7, 8'h77}) begin
            failures++; $display("FAIL rms_first_bcast got=%h want=%h", bus_obs, {1'b1, 2'd0, 3'd7, 8'h77});
        end
        add_valid = 1'b0; mul_valid = 1'b0; bch_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the result value width.
REQ-002 The block SHALL have parameter TAG_W, default 3, giving the ROB tag width (8-entry ROB).
REQ-003 The block SHALL have port clk1, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-005 The block SHALL have ports add_valid/mul_valid/bch_valid, input, 1 each, meaning a result is offered by that unit.
REQ-006 The block SHALL have ports add_tag/mul_tag/bch_tag, input, TAG_W each, the ROB tag of the offered result.
REQ-007 The block SHALL have ports add_data/mul_data/bch_data, input, DATA_W each, the offered result value.
REQ-008 The block SHALL have ports add_ready/mul_ready/bch_ready, output, 1 each, the combinational grant to that unit.
REQ-009 The block SHALL have port cdb_stall, input, 1, a ROB/regbank back-pressure request to freeze the bus.
REQ-010 The block SHALL have ports cdb_valid (1), cdb_tag (TAG_W), cdb_data (DATA_W), cdb_src (2), all outputs, forming the registered CDB broadcast; cdb_src encodes 0=add, 1=mul, 2=bch.

Function
REQ-011 A transfer SHALL occur on a rising edge where x_valid and x_ready are both 1; at most one transfer per cycle.
REQ-012 At most one x_ready SHALL be 1 in any cycle, and only when that x_valid=1 and cdb_stall=0.
REQ-013 x_ready SHALL depend only on the current valids, cdb_stall and the priority state; it SHALL NOT depend on any x_ready.
REQ-014 On a transfer, cdb_valid/cdb_tag/cdb_data/cdb_src SHALL present the winner's tag, data and source on the following cycle (1-cycle latency).
REQ-015 With cdb_stall=0 and no valid requester, cdb_valid SHALL be 0 on the next cycle; tag/data/src SHALL hold their previous values.
REQ-016 With cdb_stall=1, all outputs SHALL hold unchanged (including cdb_valid=1 if set) and no ready SHALL assert.
REQ-017 A broadcast SHALL last exactly one cycle unless held by cdb_stall; back-to-back grants SHALL give cdb_valid=1 on consecutive cycles.
REQ-018 Requesters keep valid, tag and data stable until granted; the block SHALL NOT check this and SHALL NOT drop or duplicate a result.
REQ-019 The priority state SHALL be a 2-bit pointer prio in {0,1,2}; the requester equal to prio has highest priority, then (prio+1) mod 3, then (prio+2) mod 3.
REQ-020 When CDB_RR_EN is defined, after a transfer from requester i, prio SHALL become (i+1) mod 3, with 2 wrapping to 0; prio SHALL NOT change in cycles without a transfer.
REQ-021 prio SHALL never take value 3.

Reset
REQ-022 While rst=1, cdb_valid SHALL be 0, cdb_tag 0, cdb_data 0, cdb_src 0, prio 0, and all x_ready 0, independent of clk1.
REQ-023 Reset asserted mid-stall or mid-broadcast SHALL discard the held broadcast; the first grant after release SHALL follow prio=0.

Configuration
REQ-024 The macro CDB_RR_EN SHALL select the arbitration policy.
REQ-025 With CDB_RR_EN defined, arbitration SHALL be round-robin per REQ-019/REQ-020.
REQ-026 Without CDB_RR_EN, prio SHALL be held at 0 (fixed priority add > mul > bch); all other behaviour SHALL be identical.

Verification
REQ-027 Reset with all valids 1 -> all ready 0 and cdb_valid 0 during reset; first edge after release grants add; next cycle shows cdb_valid=1, cdb_src=0, with add's tag and data.
REQ-028 Single requester: mul_valid=1, tag=5, data=8'h2A for one grant -> mul_ready=1 that cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=8'h2A, cdb_src=1; the following cycle cdb_valid=0.
REQ-029 CDB_RR_EN defined, all three valid continuously for 6 cycles -> grant order add, mul, bch, add, mul, bch; cdb_valid=1 on 6 consecutive cycles.
REQ-030 CDB_RR_EN undefined, same stimulus -> add granted on every cycle; mul and bch never granted.
REQ-031 Broadcast tag=3 in flight, cdb_stall=1 for 3 cycles with bch_valid=1 -> cdb_valid=1, cdb_tag=3 held for 3 cycles and bch_ready=0; after stall drops, bch is granted and broadcast one cycle later.
REQ-032 rst pulsed between edges during a stalled broadcast -> cdb_valid drops to 0 immediately, and prio returns to 0.
